// File: rtl/nn_fixed_pkg.sv
// -----------------------------------------------------------------------------
// nn_fixed_pkg
// Shared definitions for the signed Q16.16 neuron datapath:
//   FRAC_BITS            fractional bits of the fixed-point format
//   Q_MAX / Q_MIN        saturation limits of a 32-bit signed word
//   Q_ONE                1.0 in Q16.16
//   state_t              control FSM states of neuron_mac
//   q_clamp()            saturation value for a given overflow direction
// -----------------------------------------------------------------------------
package nn_fixed_pkg;

  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] Q_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN     = 32'h8000_0000;
  localparam logic [31:0] Q_ONE     = 32'h0001_0000;

  typedef enum logic [1:0] {
    IDLE,   // waiting for the first beat of a vector
    ACCUM,  // streaming beats of a vector
    DRAIN,  // last beat taken, pipeline emptying
    HOLD    // result presented, waiting for out_ready
  } state_t;

  // Clamp value for an overflow whose true result is negative (neg=1)
  // or positive (neg=0).
  function automatic logic [31:0] q_clamp(input logic neg);
    return neg ? Q_MIN : Q_MAX;
  endfunction

endpackage

// File: rtl/neuron_mac_sat_add32.sv
// -----------------------------------------------------------------------------
// sat_add32
// 32-bit signed saturating adder. A plain 32-bit adder (carry-in tied to 0)
// followed by two's-complement overflow detection and a clamp to Q_MAX/Q_MIN.
// Ports:
//   a, b  in  32  signed operands
//   sum   out 32  saturated sum
//   ovf   out 1   high when the raw sum overflowed and was clamped
// -----------------------------------------------------------------------------
module sat_add32
  import nn_fixed_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        ovf
);

  localparam logic C_IN = 1'b0;

  logic [31:0] raw_sum;

  // Base adder: wrap-around sum with the carry-in held at zero.
  assign raw_sum = a + b + 32'(C_IN);

  // Overflow only when both operands share a sign the result does not.
  assign ovf = (a[31] == b[31]) && (raw_sum[31] != a[31]);
  assign sum = ovf ? q_clamp(a[31]) : raw_sum;

endmodule

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
// Sequential Q16.16 multiply-accumulate neuron stage. Takes a stream of
// (activation, weight) beats, multiplies each pair (stage 1), and accumulates
// the products onto a bias captured on the first beat (stage 2), saturating
// at every step. One result is emitted per vector, with a sticky overflow flag.
//
// Optional build macro: NEURON_MAC_RELU_EN -- when defined, negative results
// are replaced with zero on out_data (out_ovf unaffected).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  block can accept a beat (IDLE/ACCUM)
//   in_x       in   activation, signed Q16.16
//   in_w       in   weight, signed Q16.16
//   in_last    in   final beat of the vector
//   bias       in   signed Q16.16, sampled on the first beat of a vector
//   out_valid  out  result valid (HOLD)
//   out_ready  in   downstream accepts the result
//   out_data   out  accumulated result, signed Q16.16
//   out_ovf    out  sticky: saturation occurred somewhere in this vector
// -----------------------------------------------------------------------------
module neuron_mac
  import nn_fixed_pkg::*;
#(
  parameter int FRAC_BITS = nn_fixed_pkg::FRAC_BITS,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_w,
  input  logic              in_last,
  input  logic [DATA_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf
);

  localparam int PW = 2 * DATA_W;

  state_t state, state_nxt;

  logic accept;
  logic first_beat;

  assign accept     = in_valid && in_ready;
  assign first_beat = accept && (state == IDLE);

  // ---------------------------------------------------------------------------
  // Stage 1: full-precision product, rescaled and saturated
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] prod_full;
  logic signed [PW-1:0] prod_shr;
  logic                 prod_fits;
  logic [DATA_W-1:0]    prod_sat;

  assign prod_full = $signed(in_x) * $signed(in_w);
  // Arithmetic shift gives floor truncation of the fractional bits.
  assign prod_shr  = prod_full >>> FRAC_BITS;
  // The rescaled product fits in DATA_W bits only if everything from the
  // result's sign bit upward is a pure sign extension.
  assign prod_fits = (&prod_shr[PW-1:DATA_W-1]) || !(|prod_shr[PW-1:DATA_W-1]);
  assign prod_sat  = prod_fits ? prod_shr[DATA_W-1:0] : q_clamp(prod_shr[PW-1]);

  logic              s1_valid;
  logic              s1_first;
  logic              s1_last;
  logic              s1_ovf;
  logic [DATA_W-1:0] s1_prod;
  logic [DATA_W-1:0] bias_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
  end

  // NOTE: pure datapath registers carry no reset; they are only consumed
  // when their qualifying valid bit (which is reset) says they are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_prod  <= prod_sat;
      s1_ovf   <= !prod_fits;
      s1_first <= first_beat;
      s1_last  <= in_last;
    end
    if (first_beat) begin
      bias_q <= bias;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturating accumulate onto bias (first beat) or running sum
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] acc;
  logic              ovf_q;
  logic              s2_done;
  logic [DATA_W-1:0] add_sum;
  logic              add_ovf;

  sat_add32 u_sat_add32 (
    .a   (s1_first ? bias_q : acc),
    .b   (s1_prod),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      ovf_q   <= 1'b0;
      s2_done <= 1'b0;
    end else begin
      // One-cycle pulse: the final product of the vector has just been added.
      s2_done <= s1_valid && s1_last;
      // The pipeline is empty in IDLE, so the clear and the accumulate below
      // never coincide.
      if (first_beat) begin
        ovf_q <= 1'b0;
      end
      if (s1_valid) begin
        acc   <= add_sum;
        ovf_q <= (s1_first ? 1'b0 : ovf_q) | s1_ovf | add_ovf;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: combinational blocks assign a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = in_last ? DRAIN : ACCUM;
      ACCUM: if (accept && in_last) state_nxt = DRAIN;
      DRAIN: if (s2_done) state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE, ACCUM: in_ready  = 1'b1;
      HOLD:        out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result
  // ---------------------------------------------------------------------------
`ifdef NEURON_MAC_RELU_EN
  assign out_data = acc[DATA_W-1] ? '0 : acc;
`else
  assign out_data = acc;
`endif
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac
// Self-checking bench for neuron_mac: a table of single-beat vectors,
// hand-written multi-cycle sequences (gaps, backpressure, mid-vector reset)
// and random vectors compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_w;
  logic        in_last;
  logic [31:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;

  always #5 clk = ~clk;

  neuron_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] w;
  } beat_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] d;   // expected accumulator value before any ReLU
    logic        o;
  } vec_t;

  beat_t beats[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef NEURON_MAC_RELU_EN
    return d[31] ? 32'h0 : d;
`else
    return d;
`endif
  endfunction

  // Reference: exact integer arithmetic with explicit range clamping.
  function automatic void model(input logic [31:0] b, input beat_t bs[$],
                                output logic [31:0] d, output logic o);
    longint max_v = 64'sd2147483647;
    longint min_v = -64'sd2147483648;
    longint acc_v = longint'($signed(b));
    longint p;
    o = 1'b0;
    foreach (bs[i]) begin
      p = (longint'($signed(bs[i].x)) * longint'($signed(bs[i].w))) >>> 16;
      if (p > max_v) begin p = max_v; o = 1'b1; end
      if (p < min_v) begin p = min_v; o = 1'b1; end
      acc_v = acc_v + p;
      if (acc_v > max_v) begin acc_v = max_v; o = 1'b1; end
      if (acc_v < min_v) begin acc_v = min_v; o = 1'b1; end
    end
    d = acc_v[31:0];
  endfunction

  // Presents the queued beats; idle cycles carry junk data. gap_idx forces
  // three idle cycles before that beat. Returns at the negedge after the
  // edge that accepted the final beat.
  task automatic drive_beats(input logic [31:0] b, input int gap_pct,
                             input int gap_idx, input bit close);
    int i     = 0;
    int guard = 0;
    int idle  = 0;
    while (i < beats.size() && guard < 500) begin
      @(negedge clk);
      guard++;
      if ((i == gap_idx && idle < 3) || (gap_pct > 0 && $urandom_range(99) < gap_pct)) begin
        if (i == gap_idx) idle++;
        in_valid = 1'b0;
        in_x     = $urandom;
        in_w     = $urandom;
        in_last  = 1'($urandom);
        bias     = $urandom;
      end else begin
        in_valid = 1'b1;
        in_x     = beats[i].x;
        in_w     = beats[i].w;
        bias     = b;
        in_last  = close && (i == beats.size() - 1);
        if (in_ready) i++;
      end
    end
    check("drive in budget", 64'(guard < 500), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vector(input string tag, input logic [31:0] b, input int gap_pct,
                            input int gap_idx, input int stall,
                            input logic [31:0] exp_d, input logic exp_o);
    int lat = 0;
    drive_beats(b, gap_pct, gap_idx, 1'b1);
    check({tag, " in_ready low after last"}, 64'(in_ready), 64'd0);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd2);
    check({tag, " data"}, 64'(out_data), 64'(exp_d));
    check({tag, " ovf"}, 64'(out_ovf), 64'(exp_o));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, " hold stable"}, {29'd0, out_valid, in_ready, out_ovf, out_data},
            {29'd0, 1'b1, 1'b0, exp_o, exp_d});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " release"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[8];
    logic [31:0] ed;
    logic        eo;
    logic [31:0] rb;

    // x, w, bias, expected acc, expected ovf
    tbl[0] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0002_8000, 1'b0};
    tbl[1] = '{32'h7FFF_0000, 32'h0002_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    tbl[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 1'b0};
    tbl[3] = '{32'hFFFF_0000, 32'h0001_8000, 32'h0000_0000, 32'hFFFE_8000, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    tbl[5] = '{32'h7FFF_0000, 32'h0001_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1};
    tbl[6] = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 1'b1};
    tbl[7] = '{32'h8000_0000, 32'h0002_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_w      = '0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset state", {29'd0, in_ready, out_valid, out_ovf, out_data},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});

    // Single-beat table
    for (int i = 0; i < 8; i++) begin
      beats = '{'{tbl[i].x, tbl[i].w}};
      run_vector($sformatf("tbl%0d", i), tbl[i].b, 0, -1, 0, relu(tbl[i].d), tbl[i].o);
    end

    // Three beats back-to-back, then the same with a forced mid-vector gap
    beats = '{'{32'h0001_0000, 32'h0001_0000},
              '{32'h0002_0000, 32'h0000_8000},
              '{32'hFFFF_8000, 32'h0002_0000}};
    run_vector("three beats", 32'h0, 0, -1, 0, 32'h0001_0000, 1'b0);
    run_vector("three beats gap", 32'h0, 0, 1, 0, 32'h0001_0000, 1'b0);

    // Backpressure: hold the result for five clocks
    beats = '{'{32'h0003_0000, 32'h0000_4000}};
    run_vector("backpressure", 32'h0001_0000, 0, -1, 5, 32'h0001_C000, 1'b0);

    // Reset mid-vector after 2 of 4 beats (the partial sum has overflowed)
    beats = '{'{32'h7FFF_0000, 32'h0002_0000}, '{32'h0001_0000, 32'h0001_0000}};
    drive_beats(32'h1234_0000, 0, -1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-vector reset", {29'd0, in_ready, out_valid, out_ovf, out_data},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
    beats = '{'{32'h0001_0000, 32'h0001_0000}};
    run_vector("after reset", 32'h0, 0, -1, 0, 32'h0001_0000, 1'b0);

    // Random vectors against the reference model
    for (int v = 0; v < 40; v++) begin
      int len;
      len   = $urandom_range(6, 1);
      beats = {};
      for (int j = 0; j < len; j++) begin
        beat_t bt;
        if ($urandom_range(3) == 0) begin
          bt.x = $urandom;
          bt.w = $urandom;
        end else begin
          bt.x = {{13{1'b0}}, 19'($urandom)} - 32'h0004_0000;
          bt.w = {{13{1'b0}}, 19'($urandom)} - 32'h0004_0000;
        end
        beats.push_back(bt);
      end
      rb = ($urandom_range(3) == 0) ? $urandom : ({{12{1'b0}}, 20'($urandom)} - 32'h0008_0000);
      model(rb, beats, ed, eo);
      run_vector($sformatf("rand%0d", v), rb, 25, -1, $urandom_range(3), relu(ed), eo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Sequential Q16.16 multiply-accumulate neuron stage that sits directly upstream of the 32-bit adder.
- Accepts a stream of (activation, weight) pairs and multiplies each pair.
- Each product is summed into a running accumulator through the adder datapath, starting from a bias.
- Emits one saturated 32-bit pre-activation per input vector to the next layer.

Parameters:
- FRAC_BITS, 16: fractional bits of the signed fixed-point format (Q16.16).
- DATA_W, 32: width of activations, weights, bias and result.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_x  in  DATA_W  activation, signed Q16.16.
- in_w  in  DATA_W  weight, signed Q16.16.
- in_last  in  1  marks the final beat of a vector.
- bias  in  DATA_W  signed Q16.16; sampled on the first beat of each vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  accumulated result, signed Q16.16.
- out_ovf  out  1  sticky; set if any saturation occurred in this vector.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset state: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, pipeline valid bits=0.
- Reset applies mid-vector too: any partial accumulation is discarded.
- Handshake: a beat transfers on clk edge with in_valid&&in_ready. The result transfers on out_valid&&out_ready.
- Stage 1 (MUL):
  - Full signed 64-bit product of in_x*in_w.
  - Result is bits [FRAC_BITS+31:FRAC_BITS], i.e. an arithmetic shift right with floor truncation.
  - If bits [63:47] are not all equal, the product saturates to 0x7FFFFFFF (positive) or 0x80000000 (negative) and the pipeline ovf flag is set.
  - Registered together with first/last tags.
- Stage 2 (ACC):
  - acc <= (first ? bias_q : acc) + prod_q, with signed saturation.
  - Overflow is detected when both operands have the same sign and the sum sign differs.
  - Any saturation ORs into the sticky ovf.
- FSM:
  - IDLE→ACCUM on the first accepted beat; bias is captured on that beat and the first tag is set.
  - ACCUM→DRAIN on an accepted beat with in_last=1. A single-beat vector goes IDLE→DRAIN directly.
  - DRAIN→HOLD after the final product has been accumulated.
  - HOLD→IDLE on out_valid&&out_ready.
- in_ready is 1 in IDLE and ACCUM, and 0 in DRAIN and HOLD.
- Latency: out_valid rises exactly 2 clocks after the edge that accepts the last beat.
- Throughput: one beat per clock inside a vector. One dead cycle is allowed after the output handshake.
- While in HOLD, out_data and out_ovf are stable until accepted.
- out_ovf clears when the next vector starts.
- Gaps are permitted: in_valid low in ACCUM stalls the stream, and the accumulator holds its value.
- Beats with in_valid=0 are ignored; in_x, in_w, in_last and bias are don't-care when in_valid=0.

Optional Feature:
- Macro: NEURON_MAC_RELU_EN.
- Defined: out_data = (acc[31] ? 0 : acc), applied combinationally on the HOLD register output. out_ovf is unaffected.
- Undefined: out_data = acc, unmodified.

Decomposition:
- Package nn_fixed_pkg holds:
  - FRAC_BITS
  - Q_MAX=32'h7FFFFFFF
  - Q_MIN=32'h80000000
  - Q_ONE=32'h00010000
  - the FSM state enum (IDLE, ACCUM, DRAIN, HOLD)
- Natural sub-module: sat_add32.
  - Wraps the existing 32-bit adder with c_in=0.
  - Adds the signed overflow detection and clamp.
  - Used by stage 2.

Test Plan:
- Single-beat vector: x=0x00010000 (1.0), w=0x00020000 (2.0), bias=0x00008000 (0.5), last=1 -> out_data=0x00028000 and out_ovf=0, with out_valid exactly 2 clocks after acceptance.
- Three back-to-back beats: (1.0,1.0), (2.0,0.5), (-0.5,2.0) with bias=0 -> 0x00010000. in_ready=0 during DRAIN/HOLD, and an in_valid gap mid-vector does not change the result.
- Overflow: x=0x7FFF0000, w=0x00020000 -> product saturates, out_data=0x7FFFFFFF, out_ovf=1. The next vector (1.0*1.0, bias 0) returns 0x00010000 with out_ovf=0.
- Negative result: x=0xFFFF0000 (-1.0), w=0x00018000 (1.5), bias=0 -> 0xFFFE8000 without the macro, 0x00000000 with NEURON_MAC_RELU_EN.
- Backpressure: out_ready held 0 for 5 clocks in HOLD -> out_valid and out_data stable, in_ready=0. Asserting out_ready returns the block to IDLE and the next vector is accepted.
- Reset mid-vector: rst_n=0 for 1 clock after 2 of 4 beats -> all outputs reach their reset values. A fresh vector then yields the correct result, uncontaminated by the discarded partial sum.
